// File: rtl/fade_engine.sv
// fade_engine: per-tick linear cross-fade of every channel between the start
// and target values held in the channel RAM. A serial restoring divider turns
// elapsed/duration into a fraction once per sweep; each channel is then
// interpolated and streamed out over a valid/ready handshake.
// Optional build macro FADE_GAMMA_EN adds an s_gamma stage that squares the
// interpolated value (o_val = v*v >> c_val_w) at the cost of one cycle per
// channel.
`default_nettype none

module fade_engine #(
  parameter int c_ledboards = 30,
  parameter int c_channels  = c_ledboards * 32,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_max_time  = 1024,
  parameter int c_time_w    = $clog2(c_max_time),
  parameter int c_val_w     = 16,
  parameter int c_frac_w    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [c_time_w-1:0] i_duration,
  input  logic                i_tick,
  output logic [c_addr_w-1:0] o_rd_addr,
  input  logic [c_val_w-1:0]  i_start_val,
  input  logic [c_val_w-1:0]  i_target_val,
  output logic [c_val_w-1:0]  o_val,
  output logic [c_addr_w-1:0] o_val_addr,
  output logic                o_val_valid,
  input  logic                i_val_ready,
  output logic                o_busy,
  output logic                o_sweep_done
);

  localparam int c_cnt_w = (c_frac_w > 1) ? $clog2(c_frac_w) : 1;
  localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(c_channels - 1);
  localparam logic [c_cnt_w-1:0]  c_last_step = c_cnt_w'(c_frac_w - 1);
  localparam logic [c_frac_w:0]   c_frac_full = {1'b1, {c_frac_w{1'b0}}};

`ifdef FADE_GAMMA_EN
  typedef enum logic [2:0] {
    s_idle, s_div, s_read, s_calc, s_gamma, s_out, s_done
  } state_t;
`else
  typedef enum logic [2:0] {
    s_idle, s_div, s_read, s_calc, s_out, s_done
  } state_t;
`endif

  // Linear interpolation start + floor((target-start)*frac / 2^c_frac_w).
  // The arithmetic shift of the signed product rounds toward -inf, which keeps
  // the result between start and target without a clamp.
  function automatic logic [c_val_w-1:0] interp(
    input logic [c_val_w-1:0]  s,
    input logic [c_val_w-1:0]  t,
    input logic [c_frac_w:0]   f
  );
    logic signed [c_val_w:0]            diff;
    logic signed [c_val_w+c_frac_w+2:0] prod;
    logic signed [c_val_w+c_frac_w+2:0] shifted;
    logic signed [c_val_w+2:0]          sum;
    diff    = $signed({1'b0, t}) - $signed({1'b0, s});
    prod    = $signed({{(c_frac_w+2){diff[c_val_w]}}, diff})
            * $signed({{(c_val_w+2){1'b0}}, f});
    shifted = prod >>> c_frac_w;
    sum     = $signed({3'b000, s}) + $signed(shifted[c_val_w+2:0]);
    return sum[c_val_w-1:0];
  endfunction

`ifdef FADE_GAMMA_EN
  // Square-law gamma: keep the upper half of v*v.
  function automatic logic [c_val_w-1:0] gamma_sq(input logic [c_val_w-1:0] v);
    logic [2*c_val_w-1:0] sq;
    sq = {{c_val_w{1'b0}}, v} * {{c_val_w{1'b0}}, v};
    return sq[2*c_val_w-1:c_val_w];
  endfunction
`endif

  // Control and output registers (async reset).
  state_t              state_q, state_d;
  logic [c_time_w-1:0] elapsed_q, elapsed_d;
  logic [c_time_w-1:0] duration_q, duration_d;
  logic                pending_q, pending_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [c_addr_w-1:0] rd_addr_q, rd_addr_d;
  logic [c_val_w-1:0]  val_q, val_d;
  logic [c_addr_w-1:0] val_addr_q, val_addr_d;
  logic                val_valid_q, val_valid_d;

  // Datapath registers (no reset; always written before use in a sweep).
  logic [c_time_w-1:0] rem_q, rem_d;
  logic [c_time_w-1:0] dur_snap_q, dur_snap_d;
  logic [c_frac_w:0]   frac_q, frac_d;
`ifdef FADE_GAMMA_EN
  logic [c_val_w-1:0]  v_q, v_d;
`endif

  // Divider step and interpolation helpers.
  logic                div_first;
  logic [c_time_w-1:0] rem_in;
  logic [c_time_w-1:0] dur_in;
  logic [c_time_w:0]   rem_sh;
  logic [c_time_w:0]   rem_sub;
  logic                div_bit;
  logic [c_time_w-1:0] rem_next;
  logic [c_frac_w-1:0] frac_in;
  logic [c_frac_w:0]   frac_next;
  logic [c_val_w-1:0]  calc_v;

  // One restoring-division step; the first step of a sweep reads the live
  // elapsed/duration directly, so that cycle doubles as the snapshot.
  always_comb begin
    div_first = (cnt_q == '0);
    rem_in    = div_first ? elapsed_q : rem_q;
    dur_in    = div_first ? duration_q : dur_snap_q;
    rem_sh    = {rem_in, 1'b0};
    rem_sub   = rem_sh - {1'b0, dur_in};
    div_bit   = (rem_sh >= {1'b0, dur_in});
    rem_next  = div_bit ? rem_sub[c_time_w-1:0] : rem_sh[c_time_w-1:0];
    frac_in   = div_first ? '0 : frac_q[c_frac_w-1:0];
    frac_next = {1'b0, frac_in[c_frac_w-2:0], div_bit};
    calc_v    = frac_q[c_frac_w] ? i_target_val
                                 : interp(i_start_val, i_target_val, frac_q);
  end

  // Time base, sweep request and sweep state machine next-state logic.
  always_comb begin
    state_d     = state_q;
    elapsed_d   = elapsed_q;
    duration_d  = duration_q;
    pending_d   = pending_q;
    cnt_d       = '0;
    rd_addr_d   = rd_addr_q;
    val_d       = val_q;
    val_addr_d  = val_addr_q;
    val_valid_d = val_valid_q;
    rem_d       = rem_q;
    dur_snap_d  = dur_snap_q;
    frac_d      = frac_q;
`ifdef FADE_GAMMA_EN
    v_d         = v_q;
`endif

    // A load restarts the fade clock and wins over a simultaneous tick.
    if (i_load) begin
      duration_d = i_duration;
      elapsed_d  = '0;
    end else if (i_tick && (elapsed_q < duration_q)) begin
      elapsed_d = elapsed_q + 1'b1;
    end

    // Ticks arriving mid-sweep collapse into a single follow-up sweep.
    if (i_tick && (state_q != s_idle)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      s_idle: begin
        if (i_tick) begin
          state_d = s_div;
        end
      end

      s_div: begin
        if (div_first) begin
          dur_snap_d = duration_q;
          if ((duration_q == '0) || (elapsed_q >= duration_q)) begin
            frac_d    = c_frac_full;
            rd_addr_d = '0;
            state_d   = s_read;
          end else begin
            rem_d  = rem_next;
            frac_d = frac_next;
            cnt_d  = cnt_q + 1'b1;
          end
        end else begin
          rem_d  = rem_next;
          frac_d = frac_next;
          if (cnt_q == c_last_step) begin
            rd_addr_d = '0;
            state_d   = s_read;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      s_read: begin
        state_d = s_calc;
      end

`ifdef FADE_GAMMA_EN
      s_calc: begin
        v_d     = calc_v;
        state_d = s_gamma;
      end

      s_gamma: begin
        val_d       = gamma_sq(v_q);
        val_addr_d  = rd_addr_q;
        val_valid_d = 1'b1;
        state_d     = s_out;
      end
`else
      s_calc: begin
        val_d       = calc_v;
        val_addr_d  = rd_addr_q;
        val_valid_d = 1'b1;
        state_d     = s_out;
      end
`endif

      s_out: begin
        if (i_val_ready) begin
          val_valid_d = 1'b0;
          if (rd_addr_q == c_last_addr) begin
            state_d = s_done;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = s_read;
          end
        end
      end

      s_done: begin
        if (pending_q || i_tick) begin
          pending_d = 1'b0;
          state_d   = s_div;
        end else begin
          state_d = s_idle;
        end
      end

      default: begin
        state_d = s_idle;
      end
    endcase
  end

  // Control/output register update with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= s_idle;
      elapsed_q   <= '0;
      duration_q  <= '0;
      pending_q   <= 1'b0;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      val_q       <= '0;
      val_addr_q  <= '0;
      val_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      elapsed_q   <= elapsed_d;
      duration_q  <= duration_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      val_q       <= val_d;
      val_addr_q  <= val_addr_d;
      val_valid_q <= val_valid_d;
    end
  end

  // Divider and intermediate datapath register update.
  always_ff @(posedge i_clk) begin
    rem_q      <= rem_d;
    dur_snap_q <= dur_snap_d;
    frac_q     <= frac_d;
`ifdef FADE_GAMMA_EN
    v_q        <= v_d;
`endif
  end

  assign o_rd_addr    = rd_addr_q;
  assign o_val        = val_q;
  assign o_val_addr   = val_addr_q;
  assign o_val_valid  = val_valid_q;
  assign o_busy       = (state_q != s_idle);
  assign o_sweep_done = (state_q == s_done);

endmodule

`default_nettype wire

// File: tb/tb_fade_engine.sv
// Testbench for fade_engine: RAM model, randomized backpressure, and a
// behavioural fade model checked against every accepted output beat.
`timescale 1ns/1ps

module tb_fade_engine;

  localparam int NCH = 960;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_load;
  logic [9:0]  i_duration;
  logic        i_tick;
  logic [9:0]  o_rd_addr;
  logic [15:0] i_start_val;
  logic [15:0] i_target_val;
  logic [15:0] o_val;
  logic [9:0]  o_val_addr;
  logic        o_val_valid;
  logic        i_val_ready;
  logic        o_busy;
  logic        o_sweep_done;

  fade_engine dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_load       (i_load),
    .i_duration   (i_duration),
    .i_tick       (i_tick),
    .o_rd_addr    (o_rd_addr),
    .i_start_val  (i_start_val),
    .i_target_val (i_target_val),
    .o_val        (o_val),
    .o_val_addr   (o_val_addr),
    .o_val_valid  (o_val_valid),
    .i_val_ready  (i_val_ready),
    .o_busy       (o_busy),
    .o_sweep_done (o_sweep_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int start_mem  [NCH];
  int target_mem [NCH];
  int got_val    [NCH];
  int exp_el  [64];
  int exp_dur [64];
  bit exp_set [64];

  int sweep_cnt = 0;
  int exp_idx   = 0;
  bit stall     = 1'b0;
  int hold_val  = 0;
  int hold_addr = 0;
  int ram_addr  = 0;
  int rdy_mode  = 0;
  int hold7     = 0;
  int m_el      = 0;
  int m_dur     = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Fade model: fraction of elapsed over duration, floor-rounded linear blend.
  function automatic int model(input int s, input int t, input int el, input int dur);
    longint fr, p, q;
    int v;
    if (dur == 0 || el >= dur) begin
      v = t;
    end else begin
      fr = (longint'(el) * 65536) / dur;
      p  = longint'(t - s) * fr;
      q  = p / 65536;
      if (p < 0 && q * 65536 != p) q = q - 1;
      v  = s + int'(q);
    end
`ifdef FADE_GAMMA_EN
    v = int'((longint'(v) * longint'(v)) >> 16);
`endif
    return v;
  endfunction

  function automatic int shaped(input int v);
`ifdef FADE_GAMMA_EN
    return int'((longint'(v) * longint'(v)) >> 16);
`else
    return v;
`endif
  endfunction

  // Synchronous channel RAM: data follows the address by one clock.
  initial begin
    i_start_val  = '0;
    i_target_val = '0;
    forever begin
      @(posedge clk);
      #1;
      i_start_val  = 16'(start_mem[ram_addr]);
      i_target_val = 16'(target_mem[ram_addr]);
      ram_addr     = int'(o_rd_addr);
    end
  end

  // Downstream ready generator.
  initial begin
    i_val_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          if (o_val_valid && o_val_addr == 10'd7 && hold7 < 3) begin
            i_val_ready = 1'b0;
            hold7++;
          end else if (o_val_addr >= 10'd5 && o_val_addr <= 10'd9) begin
            i_val_ready = 1'($urandom_range(0, 1));
          end else begin
            i_val_ready = 1'b1;
          end
        end
        2:       i_val_ready = ($urandom_range(0, 3) != 0);
        default: i_val_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: handshake stability, channel order, values, sweep length.
  always @(negedge clk) begin
    if (!i_rst_n) begin
      exp_idx = 0;
      stall   = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", int'(o_val_valid), 1);
        chk("hold_val", int'(o_val), hold_val);
        chk("hold_addr", int'(o_val_addr), hold_addr);
      end
      if (o_val_valid) begin
        if (i_val_ready) begin
          stall = 1'b0;
          chk("beat_addr", int'(o_val_addr), exp_idx);
          if (exp_set[sweep_cnt] && o_val_addr < 10'(NCH))
            chk("beat_val", int'(o_val),
                model(start_mem[o_val_addr], target_mem[o_val_addr],
                      exp_el[sweep_cnt], exp_dur[sweep_cnt]));
          if (o_val_addr < 10'(NCH)) got_val[o_val_addr] = int'(o_val);
          exp_idx++;
        end else begin
          stall     = 1'b1;
          hold_val  = int'(o_val);
          hold_addr = int'(o_val_addr);
        end
      end else begin
        stall = 1'b0;
      end
      if (o_sweep_done) begin
        chk("sweep_beats", exp_idx, NCH);
        sweep_cnt++;
        exp_idx = 0;
      end
    end
  end

  task automatic expect_sweep(input int k, input int el, input int dur);
    exp_el[k]  = el;
    exp_dur[k] = dur;
    exp_set[k] = 1'b1;
  endtask

  task automatic do_tick();
    @(posedge clk); #1 i_tick = 1'b1;
    @(posedge clk); #1 i_tick = 1'b0;
    if (m_el < m_dur) m_el++;
  endtask

  task automatic do_load(input int d);
    @(posedge clk); #1 i_load = 1'b1; i_duration = 10'(d);
    @(posedge clk); #1 i_load = 1'b0;
    m_dur = d;
    m_el  = 0;
  endtask

  task automatic do_loadtick(input int d);
    @(posedge clk); #1 i_load = 1'b1; i_tick = 1'b1; i_duration = 10'(d);
    @(posedge clk); #1 i_load = 1'b0; i_tick = 1'b0;
    m_dur = d;
    m_el  = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      total++;
      bad++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic first_valid_latency(output int n);
    n = 0;
    while (!o_val_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic fill(input int s, input int t);
    for (int i = 0; i < NCH; i++) begin
      start_mem[i]  = s;
      target_mem[i] = t;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NCH; i++) begin
      start_mem[i]  = int'($urandom_range(0, 65535));
      target_mem[i] = int'($urandom_range(0, 65535));
    end
    start_mem[0] = 0;     target_mem[0] = 65535;
    start_mem[1] = 65535; target_mem[1] = 0;
  endtask

  int k, lat, d, nt;
`ifdef FADE_GAMMA_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  initial begin
    for (int i = 0; i < 64; i++) exp_set[i] = 1'b0;
    for (int i = 0; i < NCH; i++) got_val[i] = -1;
    fill(0, 0);
    i_rst_n = 1'b0; i_load = 1'b0; i_tick = 1'b0; i_duration = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(o_val_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_sweep_done), 0);
    chk("rst_rd_addr", int'(o_rd_addr), 0);
    chk("rst_val", int'(o_val), 0);
    chk("rst_val_addr", int'(o_val_addr), 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Hand-computed pins of the model.
    chk("model_rise", model(0, 1000, 50, 100), shaped(500));
    chk("model_fall", model(1000, 0, 25, 100), shaped(750));
    chk("model_sat", model(1000, 0, 100, 100), 0);
    chk("model_zero", model(123, 4567, 1, 0), shaped(4567));
    chk("model_floor", model(10, 0, 1, 3), shaped(6));

    // Rising fade 0 -> 1000 over 100 ticks, observed at 50.
    fill(0, 1000);
    do_load(100);
    k = sweep_cnt;
    do_tick();
    expect_sweep(k, m_el, m_dur);
    first_valid_latency(lat);
    chk("div_latency", lat, 19 + EXTRA);
    for (int i = 0; i < 49; i++) do_tick();
    expect_sweep(k + 1, m_el, m_dur);
    wait_idle();
    chk("rise_sweeps", sweep_cnt - k, 2);
    chk("rise_ch0", got_val[0], shaped(500));
    chk("rise_ch480", got_val[480], shaped(500));
    chk("rise_ch959", got_val[959], shaped(500));

    // Falling fade 1000 -> 0, at 25 ticks then saturated.
    fill(1000, 0);
    do_load(100);
    k = sweep_cnt;
    do_tick();
    expect_sweep(k, m_el, m_dur);
    for (int i = 0; i < 24; i++) do_tick();
    expect_sweep(k + 1, m_el, m_dur);
    wait_idle();
    chk("fall_ch5", got_val[5], shaped(750));
    k = sweep_cnt;
    do_tick();
    expect_sweep(k, m_el, m_dur);
    for (int i = 0; i < 80; i++) do_tick();
    expect_sweep(k + 1, m_el, m_dur);
    wait_idle();
    chk("fall_sat_ch5", got_val[5], 0);
    chk("fall_sat_ch959", got_val[959], 0);

    // Zero duration: full fraction, divider skipped.
    fill(123, 4567);
    do_load(0);
    k = sweep_cnt;
    do_tick();
    expect_sweep(k, m_el, m_dur);
    first_valid_latency(lat);
    chk("zero_latency", lat, 4 + EXTRA);
    wait_idle();
    chk("zero_sweeps", sweep_cnt - k, 1);
    chk("zero_ch9", got_val[9], shaped(4567));

    // Backpressure around channel 7.
    fill_rand();
    do_load(int'($urandom_range(1, 1023)));
    for (int i = 0; i < 5; i++) do_tick();
    wait_idle();
    rdy_mode = 1;
    k = sweep_cnt;
    do_tick();
    expect_sweep(k, m_el, m_dur);
    wait_idle();
    rdy_mode = 0;
    chk("bp_sweeps", sweep_cnt - k, 1);

    // Tick coalescing: three ticks during a sweep give one more sweep.
    do_load(int'($urandom_range(10, 1023)));
    k = sweep_cnt;
    do_tick();
    expect_sweep(k, m_el, m_dur);
    for (int i = 0; i < 3; i++) do_tick();
    expect_sweep(k + 1, m_el, m_dur);
    wait_idle();
    chk("coalesce_sweeps", sweep_cnt - k, 2);
    repeat (50) @(negedge clk);
    chk("coalesce_idle", int'(o_busy), 0);

    // Load and tick together: elapsed restarts at 0 and a sweep runs.
    k = sweep_cnt;
    do_loadtick(200);
    expect_sweep(k, m_el, m_dur);
    wait_idle();
    chk("loadtick_sweeps", sweep_cnt - k, 1);
    chk("loadtick_ch3", got_val[3], shaped(start_mem[3]));
    chk("loadtick_ch700", got_val[700], shaped(start_mem[700]));

    // Asynchronous reset in the middle of a sweep.
    k = sweep_cnt;
    do_tick();
    expect_sweep(k, m_el, m_dur);
    lat = 0;
    while (!(o_val_valid && o_val_addr == 10'd400) && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    chk("reach_ch400", int'(o_val_addr), 400);
    #1 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(o_val_valid), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_rd_addr", int'(o_rd_addr), 0);
    m_el  = 0;
    m_dur = 0;
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_tick();
    expect_sweep(k, m_el, m_dur);
    wait_idle();
    chk("post_rst_sweeps", sweep_cnt - k, 1);
    chk("post_rst_ch0", got_val[0], shaped(target_mem[0]));
    chk("post_rst_ch959", got_val[959], shaped(target_mem[959]));

    // Randomized fades with random backpressure.
    for (int r = 0; r < 2; r++) begin
      fill_rand();
      d = int'($urandom_range(0, 1023));
      if (r == 1) d = int'($urandom_range(1, 60));
      do_load(d);
      nt = int'($urandom_range(1, 40));
      rdy_mode = 2;
      k = sweep_cnt;
      do_tick();
      expect_sweep(k, m_el, m_dur);
      for (int i = 1; i < nt; i++) do_tick();
      if (nt > 1) expect_sweep(k + 1, m_el, m_dur);
      wait_idle();
      rdy_mode = 0;
      chk("rand_sweeps", sweep_cnt - k, (nt > 1) ? 2 : 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
